// File: rtl/debug_terminal.sv
// Streams a timestamped status line of NUM_CH debug bytes on each timer tick and decodes
// single-character commands. Define DEBUG_TERMINAL_ECHO_EN to echo recognised command bytes.
module debug_terminal #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned TS_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tmr,
  input  logic [TS_BITS-1:0]    timestamp,
  input  logic [8*NUM_CH-1:0]   debug,
  input  logic [7:0]            rx_data,
  input  logic                  new_rx_data,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  new_tx_data,
  output logic                  motor_armed,
  output logic                  data_record,
  output logic                  reset_req,
  output logic                  busy
);

  localparam int unsigned TsDigits = TS_BITS / 4;
  localparam int unsigned ChStart  = 7 + TsDigits;
  localparam int unsigned LenHex   = 10 + TsDigits + NUM_CH * 3;
  localparam int unsigned LenBin   = 10 + TsDigits + NUM_CH * 9;
  localparam int unsigned IdxW     = $clog2(LenBin);
  localparam logic [IdxW-1:0] LastHex = IdxW'(LenHex - 1);
  localparam logic [IdxW-1:0] LastBin = IdxW'(LenBin - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                motor_q, data_q, fmt_hex_q, pause_q, overrun_q, reset_req_q;
  logic                motor_snap_q, data_snap_q, ovr_snap_q, fmt_snap_q;
  logic [TS_BITS-1:0]  ts_snap_q;
  logic [8*NUM_CH-1:0] dbg_snap_q;
  logic                snap_en, overrun_set, line_req;
  logic [7:0]          line_char;
  logic [IdxW-1:0]     last_idx;
  logic                cmd_m, cmd_d, cmd_h, cmd_p, cmd_r;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign cmd_m = new_rx_data && (rx_data == 8'h6D);
  assign cmd_d = new_rx_data && (rx_data == 8'h64);
  assign cmd_h = new_rx_data && (rx_data == 8'h68);
  assign cmd_p = new_rx_data && (rx_data == 8'h70);
  assign cmd_r = new_rx_data && (rx_data == 8'h72);

  assign motor_armed = motor_q;
  assign data_record = data_q;
  assign reset_req   = reset_req_q;
  assign last_idx    = fmt_snap_q ? LastHex : LastBin;

`ifdef DEBUG_TERMINAL_ECHO_EN
  logic [7:0] echo_q;
  logic       echo_pend_q, tmr_hold_q, echo_send, cmd_any;

  assign cmd_any  = cmd_m | cmd_d | cmd_h | cmd_p | cmd_r;
  // A tick that collides with an echo byte is replayed on the following cycle.
  assign line_req = (tmr | tmr_hold_q) & ~pause_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_q      <= 8'h00;
      echo_pend_q <= 1'b0;
      tmr_hold_q  <= 1'b0;
    end else begin
      if (cmd_any) begin
        echo_q      <= rx_data;
        echo_pend_q <= 1'b1;
      end else if (echo_send) begin
        echo_pend_q <= 1'b0;
      end
      tmr_hold_q <= echo_send & (tmr_hold_q | tmr);
    end
  end
`else
  assign line_req = tmr & ~pause_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_en     = 1'b0;
    overrun_set = 1'b0;
    new_tx_data = 1'b0;
    tx_data     = 8'h00;
    busy        = 1'b0;
`ifdef DEBUG_TERMINAL_ECHO_EN
    echo_send   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef DEBUG_TERMINAL_ECHO_EN
        if (echo_pend_q && !tx_busy) begin
          echo_send   = 1'b1;
          new_tx_data = 1'b1;
          tx_data     = echo_q;
        end else
`endif
        if (line_req) begin
          snap_en = 1'b1;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        busy        = 1'b1;
        overrun_set = tmr;
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          tx_data     = line_char;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Character at idx_q, built purely from the snapshot registers.
  always_comb begin
    int unsigned ii, rel, pos, ch, fw, base;
    logic [7:0] chan;
    ii        = 32'(idx_q);
    fw        = fmt_snap_q ? 32'd3 : 32'd9;
    rel       = 0;
    pos       = 0;
    ch        = 0;
    base      = 0;
    chan      = 8'h00;
    line_char = 8'h20;
    if (ii == 1) begin
      line_char = motor_snap_q ? 8'h41 : 8'h44;
    end else if (ii == 3) begin
      line_char = data_snap_q ? 8'h52 : 8'h49;
    end else if (ii == 5) begin
      line_char = 8'h54;
    end else if (ii == 6) begin
      line_char = 8'h3A;
    end else if (ii >= 7 && ii < ChStart) begin
      line_char = hex_char(4'(ts_snap_q >> (4 * (TsDigits - 1 - (ii - 7)))));
    end else if (ii >= ChStart && ii < ChStart + NUM_CH * fw) begin
      rel = ii - ChStart;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        base = k * fw;
        if (rel >= base && rel < base + fw) begin
          ch  = NUM_CH - 1 - k;
          pos = rel - base;
        end
      end
      chan = 8'(dbg_snap_q >> (8 * ch));
      if (pos == 0) begin
        line_char = 8'h20;
      end else if (fmt_snap_q) begin
        line_char = hex_char((pos == 1) ? chan[7:4] : chan[3:0]);
      end else begin
        line_char = {7'h18, 1'(chan >> (8 - pos))};
      end
    end else if (ii >= ChStart) begin
      rel = ii - ChStart - NUM_CH * fw;
      if (rel == 1) begin
        line_char = ovr_snap_q ? 8'h4F : 8'h2D;
      end else if (rel == 2) begin
        line_char = 8'h0D;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      motor_q      <= 1'b0;
      data_q       <= 1'b0;
      fmt_hex_q    <= 1'b0;
      pause_q      <= 1'b0;
      overrun_q    <= 1'b0;
      reset_req_q  <= 1'b0;
      motor_snap_q <= 1'b0;
      data_snap_q  <= 1'b0;
      ovr_snap_q   <= 1'b0;
      fmt_snap_q   <= 1'b0;
      ts_snap_q    <= '0;
      dbg_snap_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      reset_req_q <= cmd_r;
      if (cmd_m) motor_q   <= ~motor_q;
      if (cmd_d) data_q    <= ~data_q;
      if (cmd_h) fmt_hex_q <= ~fmt_hex_q;
      if (cmd_p) pause_q   <= ~pause_q;
      // Snapshot takes pre-command register values when a command lands on the same cycle.
      if (snap_en) begin
        ts_snap_q    <= timestamp;
        dbg_snap_q   <= debug;
        motor_snap_q <= motor_q;
        data_snap_q  <= data_q;
        ovr_snap_q   <= overrun_q;
        fmt_snap_q   <= fmt_hex_q;
        overrun_q    <= 1'b0;
      end else if (overrun_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_debug_terminal.sv
// Scoreboard bench for debug_terminal (NUM_CH=2, TS_BITS=24): expected bytes are queued when a
// tick is driven and popped on every transmit strobe.
module tb_debug_terminal;

  localparam int unsigned NCH = 2;
  localparam int unsigned TSB = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tmr = 1'b0;
  logic [TSB-1:0]   timestamp = '0;
  logic [8*NCH-1:0] debug = '0;
  logic [7:0]       rx_data = 8'h00;
  logic             new_rx_data = 1'b0;
  logic             tx_busy = 1'b0;
  logic [7:0]       tx_data;
  logic             new_tx_data, motor_armed, data_record, reset_req, busy;

  debug_terminal #(.NUM_CH(NCH), .TS_BITS(TSB)) dut (
    .clk         (clk),
    .rst         (rst),
    .tmr         (tmr),
    .timestamp   (timestamp),
    .debug       (debug),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .motor_armed (motor_armed),
    .data_record (data_record),
    .reset_req   (reset_req),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         strobe_cnt = 0;
  int         busy_cnt = 0;
  int         rreq_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit         m_motor, m_data, m_hex, m_ovr, m_pause;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cnt++;
      if (reset_req) rreq_cnt++;
      if (new_tx_data) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("extra_strobe", 32'(new_tx_data), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("tx_char", 32'(tx_data), 32'(mon_exp));
        end
      end
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Reference line built from the bench model with string formatting.
  task automatic push_line(input logic [TSB-1:0] ts, input logic [8*NCH-1:0] dbg);
    string s;
    s = $sformatf(" %s %s T:%h", m_motor ? "A" : "D", m_data ? "R" : "I", ts);
    for (int k = NCH - 1; k >= 0; k--) begin
      if (m_hex) s = {s, $sformatf(" %h", dbg[8*k +: 8])};
      else       s = {s, $sformatf(" %b", dbg[8*k +: 8])};
    end
    if (m_ovr) s = {s, " O"};
    else       s = {s, " -"};
    s = s.toupper();
    push_str(s);
    exp_q.push_back(8'h0D);
    m_ovr = 1'b0;
  endtask

  task automatic apply_cmd(input logic [7:0] c);
    case (c)
      8'h6D:   m_motor = ~m_motor;
      8'h64:   m_data  = ~m_data;
      8'h68:   m_hex   = ~m_hex;
      8'h70:   m_pause = ~m_pause;
      default: ;
    endcase
  endtask

  task automatic send_cmds(input string cs);
    @(posedge clk); #1;
    for (int i = 0; i < cs.len(); i++) begin
      rx_data     = cs[i];
      new_rx_data = 1'b1;
      apply_cmd(cs[i]);
      @(posedge clk); #1;
    end
    new_rx_data = 1'b0;
  endtask

  task automatic fire(input bit push);
    @(posedge clk); #1;
    tmr = 1'b1;
    if (push) push_line(timestamp, debug);
    @(posedge clk); #1;
    tmr = 1'b0;
  endtask

  task automatic fire_cmd(input logic [7:0] c);
    @(posedge clk); #1;
    tmr = 1'b1;
    rx_data = c;
    new_rx_data = 1'b1;
    push_line(timestamp, debug);
    apply_cmd(c);
    @(posedge clk); #1;
    tmr = 1'b0;
    new_rx_data = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (strobe_cnt < n && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("wait_strobes", 32'(strobe_cnt), 32'(n));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_new_tx", 32'(new_tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_motor", 32'(motor_armed), 32'd0);
    check_eq("rst_data", 32'(data_record), 32'd0);
    check_eq("rst_rreq", 32'(reset_req), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b1;
    timestamp = 24'h00012C;
    debug = 16'hA55A;

    // Binary line against the literal reference
    busy_cnt = 0;
    strobe_cnt = 0;
    @(posedge clk); #1;
    tmr = 1'b1;
    push_str(" D I T:00012C 10100101 01011010 -");
    exp_q.push_back(8'h0D);
    @(posedge clk); #1;
    tmr = 1'b0;
    wait_drain("t1");
    check_eq("t1_strobes", 32'(strobe_cnt), 32'd34);
    check_eq("t1_busy_cycles", 32'(busy_cnt), 32'd34);

    // Hex format
    send_cmds("h");
    strobe_cnt = 0;
    @(posedge clk); #1;
    tmr = 1'b1;
    push_str(" D I T:00012C A5 5A -");
    exp_q.push_back(8'h0D);
    @(posedge clk); #1;
    tmr = 1'b0;
    wait_drain("t2");
    check_eq("t2_strobes", 32'(strobe_cnt), 32'd22);

    // Overrun plus snapshot isolation from mid-line input changes
    timestamp = 24'h0ABCDE;
    debug = 16'h3C0F;
    strobe_cnt = 0;
    fire(1'b1);
    debug = 16'hFFFF;
    timestamp = 24'h123456;
    wait_strobes(10);
    tmr = 1'b1;
    m_ovr = 1'b1;
    @(posedge clk); #1;
    tmr = 1'b0;
    wait_drain("t3a");
    fire(1'b1);
    wait_drain("t3b");
    fire(1'b1);
    wait_drain("t3c");

    // Back-to-back commands, pause, then command coincident with a tick
    send_cmds("mdp");
    check_eq("t4_motor", 32'(motor_armed), 32'd1);
    check_eq("t4_data", 32'(data_record), 32'd1);
    strobe_cnt = 0;
    fire(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t4_paused_strobes", 32'(strobe_cnt), 32'd0);
    check_eq("t4_paused_busy", 32'(busy), 32'd0);
    send_cmds("p");
    fire_cmd(8'h6D);
    wait_drain("t4");
    check_eq("t4_motor_after", 32'(motor_armed), 32'd0);

    // tx_busy hold, then reset request pulse
    strobe_cnt = 0;
    fire(1'b1);
    wait_strobes(3);
    tx_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t5_hold_strobes", 32'(strobe_cnt), 32'd3);
    check_eq("t5_hold_busy", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    wait_drain("t5");
    check_eq("t5_strobes", 32'(strobe_cnt), 32'd22);
    rreq_cnt = 0;
    send_cmds("r");
    repeat (4) @(posedge clk);
    #1;
    check_eq("t5_rreq_cycles", 32'(rreq_cnt), 32'd1);

    // Reset mid-line
    strobe_cnt = 0;
    fire(1'b1);
    wait_strobes(12);
    rst = 1'b0;
    exp_q.delete();
    m_motor = 1'b0;
    m_data = 1'b0;
    m_hex = 1'b0;
    m_ovr = 1'b0;
    m_pause = 1'b0;
    #1;
    check_eq("t6_new_tx", 32'(new_tx_data), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_data", 32'(data_record), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    strobe_cnt = 0;
    fire(1'b1);
    wait_drain("t6");
    check_eq("t6_strobes", 32'(strobe_cnt), 32'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_terminal.md
Name: debug_terminal

Overview:
- Parametrised successor to the avionics single-byte debug terminal.
- Streams a timestamped status line for NUM_CH 8-bit debug channels to the AVR USB serial link on each timer tick.
- Decodes single-character terminal commands: motor arm, datalog, display format, pause, board reset request.
- New over the previous block: input snapshot per line, runtime hex/binary format, pause, overrun flag, reset-request output.

Parameters:
- NUM_CH, 4, number of 8-bit debug channels (1..16).
- TS_BITS, 24, timestamp width; multiple of 4, 8..32; printed as TS_BITS/4 hex digits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- tmr  in  1  one-cycle tick requesting a new line
- timestamp  in  TS_BITS  free-running time count
- debug  in  8*NUM_CH  channel k = debug[8k+7:8k]
- rx_data  in  8  byte from AVR
- new_rx_data  in  1  rx_data valid, one cycle
- tx_busy  in  1  AVR cannot accept a byte
- tx_data  out  8  byte to AVR; valid when new_tx_data=1
- new_tx_data  out  1  transmit strobe
- motor_armed  out  1  motor arm state
- data_record  out  1  datalog state
- reset_req  out  1  one-cycle board reset request
- busy  out  1  line transmission in progress

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; state IDLE; char index 0.
  - Format binary; pause off; overrun flag clear; snapshot registers 0.
- Output FSM, states IDLE and SEND:
  - IDLE: tmr=1 and not paused: latch timestamp, debug, motor, data, overrun and format into snapshot; clear overrun; index=0; go to SEND next cycle.
  - SEND: busy=1. Each cycle with tx_busy=0: new_tx_data=1, tx_data=char[index], index+1. After the last char, go to IDLE.
  - tx_busy=1: hold index; new_tx_data=0.
  - Line content comes only from the snapshot; input changes mid-line never appear in the current line.
- Line format, in order:
  - " ", motor ('A'/'D'), " ", data ('R'/'I'), " ", "T", ":".
  - TS_BITS/4 uppercase hex digits, MSB first.
  - Per channel, NUM_CH-1 down to 0: " " then 2 hex digits (hex mode) or 8 '0'/'1' chars, MSB first (binary mode).
  - " ", overrun char ('O' if set, '-' if clear), "\r".
  - Length = 10 + TS_BITS/4 + NUM_CH*(1+W), where W=2 (hex) or 8 (binary).
  - Hex digits 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
- Overrun:
  - tmr=1 while in SEND sets the overrun flag (sticky); the tick is otherwise dropped.
  - tmr=1 in IDLE while paused is ignored and does not set overrun.
- Input command decode, on new_rx_data=1 in any output state:
  - 'm': toggle motor_armed next cycle.
  - 'd': toggle data_record.
  - 'h': toggle format; takes effect at the next snapshot.
  - 'p': toggle pause; a line in progress completes.
  - 'r': reset_req=1 for exactly one cycle.
  - Any other byte: ignored.
- Simultaneous events:
  - Command and tmr in the same cycle: the snapshot captures the pre-command register values.
  - Back-to-back commands are each applied, one per cycle.
- Reset mid-line: the line is aborted at once; no further strobes are issued.

Optional Feature:
- Macro: DEBUG_TERMINAL_ECHO_EN.
- Defined:
  - Each recognised command byte is stored in a 1-deep echo buffer (a newer byte overwrites an unsent one).
  - In IDLE with tx_busy=0 and a pending echo, the echo byte is sent before starting a line.
  - A tmr arriving during the echo cycle is held pending and starts the line on the next cycle. It does not count as overrun.
- Undefined: no echo logic; the TX path is line-only.

Test Plan (NUM_CH=2, TS_BITS=24):
- Reset, then timestamp=0x00012C, debug=0xA55A, tmr pulse, tx_busy=0 -> 34 strobes, one per cycle: " D I T:00012C 10100101 01011010 -\r"; busy=1 for exactly 34 cycles.
- Send 'h', then tmr -> 22 chars: " D I T:00012C A5 5A -\r".
- tmr at char 10 of a line -> rest of the line unchanged; next line ends " O\r"; the line after ends " -\r".
- 'm', 'd', 'p' on consecutive cycles, then tmr -> motor_armed=1, data_record=1, no strobes; second 'p' then tmr -> line starts " A R".
- tx_busy held high 5 cycles at char 3 -> no strobe during the hold, index held, line content intact; 'r' -> reset_req high exactly 1 cycle.
- rst=0 at char 12 -> new_tx_data=0 and busy=0 immediately; after release, the next tmr gives a full fresh line.
